// File: rtl/serial_adder_unit_pkg.sv
// Shared types and defaults for the digit-serial adder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_adder_unit_pkg;

    localparam int SAU_WIDTH   = 32;
    localparam int SAU_DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } sau_state_e;

    // Counter width for a given digit count, never narrower than one bit.
    function automatic int sau_cnt_w(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_unit_digit_adder.sv
// One DIGIT_W-bit ripple-carry slice, used once per cycle by the serial adder.
// Latency: purely combinational.
// Backpressure: none.
module digit_ripple_adder #(
    parameter int DIGIT_W = 4
) (
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               ci,
    output logic [DIGIT_W-1:0] s,
    output logic               co
);

    logic [DIGIT_W:0] c;

    assign c[0] = ci;

    genvar i;
    generate
        for (i = 0; i < DIGIT_W; i++) begin : g_fa
            assign s[i]   = a[i] ^ b[i] ^ c[i];
            assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    endgenerate

    assign co = c[DIGIT_W];

endmodule

// File: rtl/serial_adder_unit.sv
// Digit-serial two's-complement adder: one DIGIT_W-bit digit per cycle, LSB first.
// Latency: result valid WIDTH/DIGIT_W+1 edges after the accept edge.
// Backpressure: one request in flight; in_ready only in IDLE, result held in DONE until out_ready.
module serial_adder_unit
    import serial_adder_unit_pkg::*;
#(
    parameter int WIDTH   = SAU_WIDTH,
    parameter int DIGIT_W = SAU_DIGIT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             of
);

    localparam int NDIG  = WIDTH / DIGIT_W;
    localparam int CNT_W = sau_cnt_w(NDIG);
    localparam logic [CNT_W-1:0] LAST_K = CNT_W'(NDIG - 1);

    sau_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] k_q, k_d;
    logic             carry_q, carry_d;
    logic             last_q, last_d;   // every digit has been summed
    logic             cout_q, cout_d;
    logic             of_q, of_d;

    logic [DIGIT_W-1:0] dig_a, dig_b, dig_s;
    logic               dig_co;

    // Current digit of the latched operands.
    assign dig_a = a_q[int'(k_q)*DIGIT_W +: DIGIT_W];
    assign dig_b = b_q[int'(k_q)*DIGIT_W +: DIGIT_W];

    digit_ripple_adder #(
        .DIGIT_W (DIGIT_W)
    ) u_digit (
        .a  (dig_a),
        .b  (dig_b),
        .ci (carry_q),
        .s  (dig_s),
        .co (dig_co)
    );

    // Next-state: accept in IDLE, one digit per CALC edge then a finalise edge, hold in DONE.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        k_d     = k_q;
        carry_d = carry_q;
        last_d  = last_q;
        cout_d  = cout_q;
        of_d    = of_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    carry_d = cin;
                    k_d     = '0;
                    sum_d   = '0;
                    last_d  = 1'b0;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (last_q) begin
                    // Flags are derived from the completed sum and latched operands.
                    cout_d  = carry_q;
                    of_d    = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_q[WIDTH-1] != a_q[WIDTH-1]);
                    state_d = DONE;
                end else begin
                    sum_d[int'(k_q)*DIGIT_W +: DIGIT_W] = dig_s;
                    carry_d = dig_co;
                    k_d     = k_q + 1'b1;
                    if (k_q == LAST_K) begin
                        last_d = 1'b1;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            k_q     <= '0;
            carry_q <= 1'b0;
            last_q  <= 1'b0;
            cout_q  <= 1'b0;
            of_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            last_q  <= last_d;
            cout_q  <= cout_d;
            of_q    <= of_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign of        = of_q;

endmodule

// File: tb/tb_serial_adder_unit.sv
// Directed and random checks of serial_adder_unit against an A+B+cin model.
// Latency: expects out_valid 9 edges after accept at default parameters.
// Backpressure: exercises held out_ready and ignored in_valid while busy.
module tb_serial_adder_unit;

    localparam int W   = 32;
    localparam int LAT = 9;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         of;

    int errors = 0;
    int checks = 0;

    serial_adder_unit #(
        .WIDTH   (32),
        .DIGIT_W (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .of        (of)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic on the operands.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         output logic [W-1:0] s, output logic co, output logic ov);
        logic [W:0] full;
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        s    = full[W-1:0];
        co   = full[W];
        ov   = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    endtask

    // One full request/response transaction; inputs are scrambled while busy.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         input int hold, input bit noise);
        logic [W-1:0] es;
        logic         ec, eo;
        logic [W-1:0] s0;
        logic         c0, o0;
        int           n;
        model(a, b, ci, es, ec, eo);
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("ready_before_accept", 64'(in_ready), 64'd1);
        A = a; B = b; cin = ci; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("busy_after_accept", 64'(in_ready), 64'd0);
        n = 0;
        while (!out_valid && n < 50) begin
            if (noise) begin
                A = $urandom; B = $urandom; cin = 1'($urandom);
                in_valid = 1'($urandom);
            end
            @(posedge clk); #1; n++;
        end
        in_valid = 1'b0;
        chk("latency", 64'(n), 64'(LAT));
        chk("sum", 64'(sum), 64'(es));
        chk("cout", 64'(cout), 64'(ec));
        chk("of", 64'(of), 64'(eo));
        s0 = sum; c0 = cout; o0 = of;
        for (int i = 0; i < hold; i++) begin
            if (noise) begin
                A = $urandom; B = $urandom; in_valid = 1'($urandom);
            end
            @(posedge clk); #1;
            chk("hold_stable", {31'd0, out_valid, in_ready, c0 ^ cout, o0 ^ of, s0 ^ sum},
                {31'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("handoff", {62'd0, out_valid, in_ready}, {62'd0, 1'b0, 1'b1});
        chk("idle_keeps_sum", 64'(sum), 64'(es));
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; cin = 1'b0;
        rst_n = 1'b0;
        #23;
        chk("reset_state", {29'd0, in_ready, out_valid, cout, of, sum},
            {29'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0});
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Directed corner cases.
        do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0, 1'b0);
        do_op(32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1, 1'b1);
        do_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
        do_op(32'h0000_0001, 32'h8000_0000, 1'b0, 0, 1'b1);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5, 1'b1);

        // Reset in the middle of CALC abandons the operation.
        A = 32'h1234_5678; B = 32'h1111_1111; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_calc_reset", {29'd0, in_ready, out_valid, cout, of, sum},
            {29'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0});
        @(negedge clk);
        rst_n = 1'b1;
        do_op(32'd5, 32'd3, 1'b0, 0, 1'b0);

        // Random back-to-back traffic with random backpressure.
        for (int t = 0; t < 40; t++) begin
            ra = $urandom; rb = $urandom;
            do_op(ra, rb, 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_adder_unit.md
SERIAL_ADDER_UNIT -- requirements
Module: serial_adder_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/sum width in bits.
REQ-002 SHALL have parameter DIGIT_W, default 4, bits added per cycle; WIDTH % DIGIT_W == 0 is required.
REQ-003 SHALL have port clk, input, 1, single clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, operand request present.
REQ-006 SHALL have port in_ready, output, 1, unit can accept a request.
REQ-007 SHALL have ports A and B, input, WIDTH each, two's-complement operands.
REQ-008 SHALL have port cin, input, 1, carry-in.
REQ-009 SHALL have port out_valid, output, 1, result present.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-011 SHALL have port sum, output, WIDTH, result bits (A+B+cin) mod 2^WIDTH.
REQ-012 SHALL have ports cout and of, output, 1 each: carry out of the MSB; signed overflow.

Function
REQ-013 SHALL implement FSM states IDLE, CALC and DONE.
REQ-014 in_ready SHALL equal (state==IDLE); out_valid SHALL equal (state==DONE).
REQ-015 On an edge with in_valid && in_ready: SHALL latch A, B and cin, clear digit counter and sum register, and go IDLE->CALC.
REQ-016 In CALC, each edge SHALL add digit k (bits k*DIGIT_W+DIGIT_W-1 : k*DIGIT_W) of A and B plus the carry register, store the digit into sum, update the carry, and increment k, LSB digit first.
REQ-017 After digit WIDTH/DIGIT_W-1 is processed, SHALL go CALC->DONE; out_valid SHALL rise exactly WIDTH/DIGIT_W+1 edges after the accept edge (9 edges at defaults).
REQ-018 cout SHALL be the final carry; of SHALL be (A[MSB]==B[MSB]) && (sum[MSB]!=A[MSB]), using latched operands.
REQ-019 In DONE, sum, cout and of SHALL hold stable while out_ready is low.
REQ-020 On an edge in DONE with out_ready high: SHALL go DONE->IDLE; in_ready SHALL rise the following cycle, with no overlap.
REQ-021 Input changes on A/B/cin during CALC or DONE SHALL NOT affect the result in progress.
REQ-022 in_valid while not in_ready SHALL be ignored and not queued.
REQ-023 sum, cout and of SHALL keep the last result in IDLE until the next accept.

Reset
REQ-024 rst_n low SHALL force state=IDLE; counter, carry, operand and sum registers, cout and of to 0, immediately and independent of clk.
REQ-025 Reset during CALC or DONE SHALL abandon the operation; out_valid=0, in_ready=1 from reset assertion.
REQ-026 First accept SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-027 A shared package SHALL hold the state enum (IDLE/CALC/DONE) and the default WIDTH/DIGIT_W constants.
REQ-028 The per-cycle digit addition SHALL be one sub-module, digit_ripple_adder (DIGIT_W-bit ripple carry: a, b, ci -> s, co).
REQ-029 Counter width SHALL be clog2(WIDTH/DIGIT_W), minimum 1.

Verification
REQ-030 A=0x7FFFFFFF, B=0x00000001, cin=0 -> sum=0x80000000, cout=0, of=1, out_valid 9 edges after accept.
REQ-031 A=0xFFFFFFFF, B=0x80000000, cin=0 -> sum=0x7FFFFFFF, cout=1, of=1.
REQ-032 A=0x7FFFFFFF, B=0xFFFFFFFF -> 0x7FFFFFFE, cout=1, of=0; A=0x00000001, B=0x80000000 -> 0x80000001, cout=0, of=0.
REQ-033 A=B=0xFFFFFFFF, cin=1 -> sum=0xFFFFFFFF, cout=1, of=0; out_ready held low 5 cycles -> outputs stable, in_ready stays 0.
REQ-034 rst_n pulsed low at CALC edge 4 -> out_valid=0, in_ready=1 immediately; next request A=5, B=3 -> sum=8.
REQ-035 Randomized back-to-back requests with out_ready random, compared against a behavioural A+B+cin model; no dropped or duplicated results.
